// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter: FSM state codes,
// default sizes and the round-robin winner search.
package regfile_pkg;

    localparam int DefDataWidth = 8;
    localparam int DefNumRegs   = 16;
    localparam int MaxReq       = 32;

    typedef logic [0:0] state_t;
    localparam state_t StRun   = 1'b0;
    localparam state_t StClear = 1'b1;

    // First set bit of req searching from ptr+1 upward, wrapping modulo num_req; -1 if none.
    function automatic int rr_next(input logic [MaxReq-1:0] req, input int ptr, input int num_req);
        int idx;
        rr_next = -1;
        for (int k = num_req; k >= 1; k--) begin
            idx = (ptr + k) % num_req;
            if (req[idx]) begin
                rr_next = idx;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// after ptr, suppressed entirely when enable is low.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NumReq     = 4,
    parameter int ReqIdWidth = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]     req,
    input  logic [ReqIdWidth-1:0] ptr,
    input  logic                  enable,
    output logic [NumReq-1:0]     grant,
    output logic [ReqIdWidth-1:0] grant_idx,
    output logic                  any_grant
);

    logic [MaxReq-1:0] req_ext;
    int                winner;

    always_comb begin
        req_ext             = '0;
        req_ext[NumReq-1:0] = req;
        winner              = rr_next(req_ext, int'(ptr), NumReq);
        grant               = '0;
        grant_idx           = '0;
        any_grant           = 1'b0;
        if (enable && (winner >= 0)) begin
            grant[winner] = 1'b1;
            grant_idx     = ReqIdWidth'(winner);
            any_grant     = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares one register-file write port among NumReq requesters and sequences
// a zero-fill of registers 1..NumRegs-1 on request.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DataWidth  = DefDataWidth,
    parameter int NumRegs    = DefNumRegs,
    parameter int IndexWidth = $clog2(NumRegs),
    parameter int NumReq     = 4,
    parameter int ReqIdWidth = $clog2(NumReq)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NumReq-1:0]                    reqValid,
    output logic [NumReq-1:0]                    reqReady,
    input  logic [NumReq-1:0][IndexWidth-1:0]    reqAddr,
    input  logic [NumReq-1:0][DataWidth-1:0]     reqData,
    input  logic                                 clearStart,
    output logic                                 clearBusy,
    output logic                                 rfWriteEn,
    output logic [IndexWidth-1:0]                rfWriteAddr,
    output logic [DataWidth-1:0]                 rfWriteData,
    output logic [ReqIdWidth-1:0]                grantId,
    output logic                                 droppedR0
);

    localparam logic [IndexWidth:0] LastAddr = (IndexWidth+1)'(NumRegs - 1);

    state_t                  state;
    logic [ReqIdWidth-1:0]   rr_ptr;
    logic [IndexWidth:0]     clr_cnt;
    logic                    arb_en;
    logic [NumReq-1:0]       grant;
    logic [ReqIdWidth-1:0]   win_id;
    logic                    any_grant;
    logic                    win_r0;

    logic                    busy_p1;
    logic                    wr_en_p1;
    logic [IndexWidth-1:0]   wr_addr_p1;
    logic [DataWidth-1:0]    wr_data_p1;
    logic [ReqIdWidth-1:0]   gid_p1;
    logic                    drop_p1;

    // Stage 0: combinational arbitration against the current requests
    assign arb_en = !rst && (state == StRun) && !clearStart;
    assign win_r0 = (reqAddr[win_id] == '0);

    rr_arbiter #(
        .NumReq     (NumReq),
        .ReqIdWidth (ReqIdWidth)
    ) u_arb (
        .req       (reqValid),
        .ptr       (rr_ptr),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (win_id),
        .any_grant (any_grant)
    );

    assign reqReady = grant;

    // Stage 1: registered write port, FSM and clear counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StRun;
            rr_ptr     <= ReqIdWidth'(NumReq - 1);
            clr_cnt    <= '0;
            busy_p1    <= 1'b0;
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
            gid_p1     <= '0;
            drop_p1    <= 1'b0;
        end else if (state == StClear) begin
            wr_en_p1   <= 1'b1;
            wr_addr_p1 <= clr_cnt[IndexWidth-1:0];
            wr_data_p1 <= '0;
            drop_p1    <= 1'b0;
            clr_cnt    <= clr_cnt + 1'b1;
            if (clr_cnt == LastAddr) begin
                state   <= StRun;
                busy_p1 <= 1'b0;
            end
        end else if (clearStart) begin
            state    <= StClear;
            busy_p1  <= 1'b1;
            clr_cnt  <= (IndexWidth+1)'(1);
            wr_en_p1 <= 1'b0;
            drop_p1  <= 1'b0;
        end else if (any_grant) begin
            rr_ptr <= win_id;
            gid_p1 <= win_id;
            // Register 0 is hardwired: the request is consumed but never written
            if (win_r0) begin
                wr_en_p1 <= 1'b0;
                drop_p1  <= 1'b1;
            end else begin
                wr_en_p1   <= 1'b1;
                wr_addr_p1 <= reqAddr[win_id];
                wr_data_p1 <= reqData[win_id];
                drop_p1    <= 1'b0;
            end
        end else begin
            wr_en_p1 <= 1'b0;
            drop_p1  <= 1'b0;
        end
    end

    assign clearBusy   = busy_p1;
    assign rfWriteEn   = wr_en_p1;
    assign rfWriteAddr = wr_addr_p1;
    assign rfWriteData = wr_data_p1;
    assign grantId     = gid_p1;
    assign droppedR0   = drop_p1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: a queue-based reference model checked every
// cycle, a behavioural register file behind the write port, and directed scenarios.
module tb_regfile_write_arbiter;

    localparam int NR = 4;
    localparam int NREG = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR-1:0]        reqValid;
    logic [NR-1:0]        reqReady;
    logic [NR-1:0][3:0]   reqAddr;
    logic [NR-1:0][7:0]   reqData;
    logic                 clearStart;
    logic                 clearBusy;
    logic                 rfWriteEn;
    logic [3:0]           rfWriteAddr;
    logic [7:0]           rfWriteData;
    logic [1:0]           grantId;
    logic                 droppedR0;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [7:0] rf [NREG];

    // Reference model state
    int         m_ptr;
    int         m_q[$];
    logic       e_en;
    logic [3:0] e_addr;
    logic [7:0] e_data;
    int         e_gid;
    logic       e_drop;

    regfile_write_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .reqValid    (reqValid),
        .reqReady    (reqReady),
        .reqAddr     (reqAddr),
        .reqData     (reqData),
        .clearStart  (clearStart),
        .clearBusy   (clearBusy),
        .rfWriteEn   (rfWriteEn),
        .rfWriteAddr (rfWriteAddr),
        .rfWriteData (rfWriteData),
        .grantId     (grantId),
        .droppedR0   (droppedR0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rfWriteEn === 1'b1) rf[rfWriteAddr] <= rfWriteData;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int k = 1; k <= NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        if (rst) begin
            m_q.delete();
            m_ptr = NR - 1;
            e_en = 1'b0; e_addr = '0; e_data = '0; e_gid = 0; e_drop = 1'b0;
        end else if (m_q.size() > 0) begin
            e_addr = 4'(m_q.pop_front());
            e_en = 1'b1; e_data = '0; e_drop = 1'b0;
        end else if (clearStart) begin
            for (int a = 1; a < NREG; a++) m_q.push_back(a);
            e_en = 1'b0; e_drop = 1'b0;
        end else begin
            w = pick(reqValid, m_ptr);
            if (w >= 0) begin
                m_ptr = w;
                e_gid = w;
                if (reqAddr[w] == 4'd0) begin
                    e_en = 1'b0; e_drop = 1'b1;
                end else begin
                    e_en = 1'b1; e_addr = reqAddr[w]; e_data = reqData[w]; e_drop = 1'b0;
                end
            end else begin
                e_en = 1'b0; e_drop = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [NR-1:0] er;
        int w;
        if (chk_en) begin
            er = '0;
            w = pick(reqValid, m_ptr);
            if (!rst && !clearStart && (m_q.size() == 0) && (w >= 0)) er[w] = 1'b1;
            chk("model_ready", 32'(reqReady), 32'(er));
            chk("model_busy", 32'(clearBusy), 32'(m_q.size() > 0));
            chk("model_en", 32'(rfWriteEn), 32'(e_en));
            chk("model_addr", 32'(rfWriteAddr), 32'(e_addr));
            chk("model_data", 32'(rfWriteData), 32'(e_data));
            chk("model_gid", 32'(grantId), 32'(e_gid));
            chk("model_drop", 32'(droppedR0), 32'(e_drop));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload_5a();
        for (int k = 1; k < NREG; k++) begin
            reqValid = 4'b0001;
            reqAddr[0] = 4'(k);
            reqData[0] = 8'h5A;
            tick();
        end
        reqValid = '0;
        tick();
    endtask

    initial begin
        int busy_cnt;
        rst = 1'b1; clearStart = 1'b0; reqValid = 4'b1111; reqAddr = '0; reqData = '0;
        for (int a = 0; a < NREG; a++) rf[a] = 8'h00;
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(reqReady), 32'h0);
        chk("rst_busy", 32'(clearBusy), 32'h0);
        chk("rst_en", 32'(rfWriteEn), 32'h0);
        chk("rst_addr", 32'(rfWriteAddr), 32'h0);
        chk("rst_gid", 32'(grantId), 32'h0);
        chk("rst_drop", 32'(droppedR0), 32'h0);
        rst = 1'b0; reqValid = '0;
        tick();

        // Single requester
        reqValid = 4'b0010; reqAddr[1] = 4'd5; reqData[1] = 8'hAA;
        @(negedge clk);
        chk("t1_ready", 32'(reqReady), 32'h2);
        tick();
        reqValid = '0;
        @(negedge clk);
        chk("t1_en", 32'(rfWriteEn), 32'h1);
        chk("t1_addr", 32'(rfWriteAddr), 32'h5);
        chk("t1_data", 32'(rfWriteData), 32'hAA);
        chk("t1_gid", 32'(grantId), 32'h1);
        tick();
        chk("t1_rf5", 32'(rf[5]), 32'hAA);

        // All four requesters continuously valid from reset
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            reqAddr[i] = 4'(8 + i);
            reqData[i] = 8'(8'hC0 + i);
        end
        reqValid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("t2_gid", 32'(grantId), 32'((k - 1) % 4));
                chk("t2_data", 32'(rfWriteData), 32'(8'hC0 + (k - 1) % 4));
            end
            chk("t2_ready", 32'(reqReady), 32'(1 << (k % 4)));
            tick();
        end
        reqValid = '0;
        @(negedge clk);
        chk("t2_gid_last", 32'(grantId), 32'h3);
        chk("t2_data_last", 32'(rfWriteData), 32'hC3);
        tick();

        // Write to register 0 is consumed and dropped
        reqValid = 4'b0100; reqAddr[2] = 4'd0; reqData[2] = 8'h11;
        @(negedge clk);
        chk("t3_ready", 32'(reqReady), 32'h4);
        tick();
        reqValid = '0;
        @(negedge clk);
        chk("t3_en", 32'(rfWriteEn), 32'h0);
        chk("t3_drop", 32'(droppedR0), 32'h1);
        tick();
        @(negedge clk);
        chk("t3_drop_end", 32'(droppedR0), 32'h0);
        chk("t3_rf0", 32'(rf[0]), 32'h0);

        // Full clear with every requester waiting, a second clearStart mid-clear
        preload_5a();
        for (int i = 0; i < NR; i++) begin
            reqAddr[i] = 4'(i + 1);
            reqData[i] = 8'(8'hD0 + i);
        end
        reqValid = 4'b1111; clearStart = 1'b1;
        @(negedge clk);
        chk("t4_ready_start", 32'(reqReady), 32'h0);
        tick();
        clearStart = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < NREG - 1; k++) begin
            clearStart = (k == 5);
            @(negedge clk);
            chk("t4_ready_clr", 32'(reqReady), 32'h0);
            if (clearBusy === 1'b1) busy_cnt++;
            tick();
        end
        clearStart = 1'b0;
        @(negedge clk);
        chk("t4_busy_end", 32'(clearBusy), 32'h0);
        chk("t4_busy_cycles", 32'(busy_cnt), 32'd15);
        chk("t4_resume_ready", 32'(reqReady), 32'h2);
        reqValid = '0;
        tick();
        for (int a = 0; a < NREG; a++) chk("t4_rf_zero", 32'(rf[a]), 32'h0);

        // Reset in the fifth cycle of a clear
        preload_5a();
        clearStart = 1'b1;
        tick();
        clearStart = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(clearBusy), 32'h0);
        chk("t5_en", 32'(rfWriteEn), 32'h0);
        tick();
        for (int a = 1; a < NREG; a++)
            chk("t5_rf", 32'(rf[a]), (a <= 4) ? 32'h0 : 32'h5A);
        reqValid = 4'b1111;
        @(negedge clk);
        chk("t5_first_grant", 32'(reqReady), 32'h1);
        reqValid = '0;
        tick();

        // Requester 3 withdraws while requester 1 is served twice
        reqAddr[1] = 4'd6; reqData[1] = 8'h66; reqAddr[3] = 4'd9; reqData[3] = 8'h33;
        reqValid = 4'b1010;
        @(negedge clk);
        chk("t6_ready1", 32'(reqReady), 32'h2);
        tick();
        reqValid = 4'b0010; reqAddr[1] = 4'd7; reqData[1] = 8'h67;
        @(negedge clk);
        chk("t6_ready2", 32'(reqReady), 32'h2);
        chk("t6_gid", 32'(grantId), 32'h1);
        tick();
        reqValid = '0;
        tick();
        tick();
        chk("t6_rf9", 32'(rf[9]), 32'h5A);
        chk("t6_rf6", 32'(rf[6]), 32'h66);
        chk("t6_rf7", 32'(rf[7]), 32'h67);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
